uart_rx_vote_sampler: RTL and testbench

//  UART receive front end: oversamples the serial line, presents 3 mid-bit samples per bit on smp_o to the

---
 rtl/uart_rx_vote_sampler.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_vote_sampler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_vote_sampler.sv
// uart_rx_vote_sampler
//   UART receive front end. The serial line is synchronised and oversampled.
//   Three mid-bit samples per bit are presented on smp_o to an external
//   3-input majority voter, and its vote (maj_i) is consumed one tick later.
//   Start, data (LSB first), optional parity and stop bits are assembled into
//   a byte, with framing and parity checks.
//
//   Optional feature: define UART_RX_PARITY_EN to insert an even-parity bit
//   between the data and stop bits. Without it, par_err is tied to 0.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   tick       oversample enable, OVS ticks per bit period
//   rxd        raw serial line, idle high, asynchronous to clk
//   smp_o      samples to the voter, [2]=oldest, [0]=newest
//   maj_i      voter result for smp_o (combinational, same cycle)
//   data_o     last good byte, held until the next good frame
//   valid_o    1-cycle pulse when data_o is updated
//   frame_err  1-cycle pulse when the stop vote was 0
//   par_err    1-cycle pulse on parity mismatch (parity build only)
//   busy       high whenever a frame is in progress
module uart_rx_vote_sampler #(
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [2:0]           smp_o,
  input  logic                 maj_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err,
  output logic                 par_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int C  = OVS / 2;

  localparam logic [CW-1:0] CAP_LO  = CW'(C - 1);
  localparam logic [CW-1:0] CAP_MID = CW'(C);
  localparam logic [CW-1:0] CAP_HI  = CW'(C + 1);
  localparam logic [CW-1:0] VOTE_PT = CW'(C + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(OVS - 1);
  localparam logic [BW-1:0] BIT_END = BW'(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, rxs_q, rxs_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 in_frame, capture, vote, bit_end;
`ifdef UART_RX_PARITY_EN
  logic                 par_flag_q, par_flag_d;
  logic                 perr_q, perr_d;
`endif

  // Two-flop synchroniser, preset to idle level. rxs_prev_q keeps the value
  // seen at the previous tick so the start edge is judged on tick boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
      if (tick) rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      smp_q    <= '1;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      smp_q    <= smp_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_flag_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      par_flag_q <= par_flag_d;
      perr_q     <= perr_d;
    end
  end
`endif

  always_comb begin
    in_frame = (state_q != IDLE);
    capture  = tick && in_frame &&
               ((cnt_q == CAP_LO) || (cnt_q == CAP_MID) || (cnt_q == CAP_HI));
    // smp_o has been stable since the last capture, so maj_i is settled here.
    vote     = tick && in_frame && (cnt_q == VOTE_PT);
    bit_end  = tick && (cnt_q == CNT_MAX);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    smp_d    = smp_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_flag_d = par_flag_q;
    perr_d     = 1'b0;
`endif

    if (capture) smp_d = {smp_q[1:0], rxs_q};
    if (tick && in_frame) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tick && rxs_prev_q && !rxs_q) begin
          state_d  = START;
          bitcnt_d = '0;
`ifdef UART_RX_PARITY_EN
          par_flag_d = 1'b0;
`endif
        end
      end
      START: begin
        if (vote && maj_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          smp_d   = '1;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (vote) begin
          shreg_d  = {maj_i, shreg_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + BW'(1);
        end
        // bitcnt_q already includes this bit's vote by the end of the bit.
        if (bit_end && (bitcnt_q == BIT_END)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (vote && (maj_i != ^shreg_q)) par_flag_d = 1'b1;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Leave half a bit early so a back-to-back start edge is not missed.
        if (vote) begin
          state_d = IDLE;
          cnt_d   = '0;
          smp_d   = '1;
          if (!maj_i) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_flag_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        smp_d   = '1;
      end
    endcase
  end

  assign smp_o     = smp_q;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign par_err   = perr_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Testbench for uart_rx_vote_sampler (OVS=16, DATA_BITS=8, tick every cycle).
// A 3-input majority voter closes the smp_o/maj_i loop. Expected events are
// queued when each frame is driven and compared when the DUT pulses.
// Parity frames are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_vote_sampler;

  localparam int OVS = 16;
  localparam int DB  = 8;
  localparam int K_VALID = 1;
  localparam int K_FE    = 2;
  localparam int K_PE    = 4;

  logic          clk = 1'b0;
  logic          rst_n, tick, rxd, maj;
  logic [2:0]    smp;
  logic [DB-1:0] data;
  logic          valid, ferr, perr, busy;

  always #5 clk = ~clk;

  assign maj = (smp[2] & smp[1]) | (smp[2] & smp[0]) | (smp[1] & smp[0]);

  uart_rx_vote_sampler #(.OVS(OVS), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .rxd       (rxd),
    .smp_o     (smp),
    .maj_i     (maj),
    .data_o    (data),
    .valid_o   (valid),
    .frame_err (ferr),
    .par_err   (perr),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         glitch_slot;  // frame slot (0=start) with a 1-clk mid-bit glitch, -1 none
    logic       par_inv;      // drive the wrong parity bit
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_slot(input logic v, input bit glitch);
    for (int i = 0; i < OVS; i++) begin
      rxd = (glitch && i == OVS / 2) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gslot,
                            input logic par_inv);
    drive_slot(1'b0, gslot == 0);
    for (int b = 0; b < DB; b++) drive_slot(d[b], gslot == b + 1);
`ifdef UART_RX_PARITY_EN
    drive_slot((^d) ^ par_inv, gslot == DB + 1);
`endif
    drive_slot(stop, 1'b0);
    rxd = 1'b1;
    repeat (OVS) @(negedge clk);
  endtask

  // Scoreboard consumer: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (valid || ferr || perr)) begin
      int   k;
      exp_t e;
      k = (valid ? K_VALID : 0) + (ferr ? K_FE : 0) + (perr ? K_PE : 0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got kind %0d data %0h expected none", k, data);
      end else begin
        e = sb.pop_front();
        check("event_kind", k, e.kind);
        check("data_o", data, e.data);
        if (valid) check("busy_after_stop", busy, 1'b0);
      end
    end
  end

  initial begin
    logic [7:0] last;
    logic [7:0] part;

    vecs.push_back('{8'h55, 1'b1, -1, 1'b0, K_VALID, 8'h55});
    vecs.push_back('{8'hA3, 1'b1,  3, 1'b0, K_VALID, 8'hA3});
    vecs.push_back('{8'h3C, 1'b0, -1, 1'b0, K_FE,    8'hA3});
    vecs.push_back('{8'hFF, 1'b1,  5, 1'b0, K_VALID, 8'hFF});
    vecs.push_back('{8'h00, 1'b0, -1, 1'b0, K_FE,    8'hFF});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, -1, 1'b0, K_VALID, 8'h07});
    vecs.push_back('{8'h07, 1'b1, -1, 1'b1, K_PE,    8'h07});
    vecs.push_back('{8'hE1, 1'b1, -1, 1'b1, K_PE,    8'h07});
`endif

    rxd   = 1'b1;
    tick  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_smp_o", smp, 3'b111);
    check("rst_data_o", data, 8'h00);
    check("rst_valid_o", valid, 1'b0);
    check("rst_frame_err", ferr, 1'b0);
    check("rst_par_err", perr, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) begin
      sb.push_back('{vecs[i].exp_kind, vecs[i].exp_data});
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].glitch_slot, vecs[i].par_inv);
    end
    last = vecs[vecs.size() - 1].exp_data;

    // False start: 3-clk low pulse, start vote is 1, no pulse expected.
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    check("false_start_busy_hi", busy, 1'b1);
    rxd = 1'b1;
    repeat (2 * OVS) @(negedge clk);
    check("false_start_busy_lo", busy, 1'b0);
    check("false_start_data", data, last);
    check("false_start_smp", smp, 3'b111);

    // Reset in the middle of data bit 4 of 0x5A; partial byte must vanish.
    part = 8'h5A;
    drive_slot(1'b0, 1'b0);
    for (int b = 0; b < 4; b++) drive_slot(part[b], 1'b0);
    rxd = part[4];
    repeat (OVS / 2) @(negedge clk);
    check("mid_frame_busy", busy, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_data_o", data, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_smp_o", smp, 3'b111);
    check("midrst_valid_o", valid, 1'b0);
    rst_n = 1'b1;
    rxd   = 1'b1;
    repeat (2 * OVS) @(negedge clk);

    sb.push_back('{K_VALID, 8'h81});
    send_frame(8'h81, 1'b1, -1, 1'b0);

    repeat (4 * OVS) @(negedge clk);
    check("all_events_seen", sb.size(), 0);
    check("final_data_o", data, 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
